// File: rtl/register_writeback_if.sv
// Bus bundle for the register writeback front end: the ALU and memory-load
// request handshakes, the register file write port, and the decode-side
// pending lookups. The producer/decode side uses the master modport and the
// writeback block uses the slave modport.
interface register_writeback_if #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 4,
  parameter int DEPTH        = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    alu_valid;
  logic [ADDRESS_BITS-1:0] alu_addr;
  logic [BITS-1:0]         alu_data;
  logic                    alu_ready;

  logic                    mem_valid;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [BITS-1:0]         mem_data;
  logic                    mem_ready;

  logic [ADDRESS_BITS-1:0] wb_addr;
  logic [BITS-1:0]         wb_data;

  logic [ADDRESS_BITS-1:0] rd_addr_a;
  logic [ADDRESS_BITS-1:0] rd_addr_b;
  logic                    pending_a;
  logic                    pending_b;

  logic [CW-1:0]           count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output rd_addr_a, rd_addr_b,
    input  alu_ready, mem_ready,
    input  wb_addr, wb_data,
    input  pending_a, pending_b,
    input  count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  rd_addr_a, rd_addr_b,
    output alu_ready, mem_ready,
    output wb_addr, wb_data,
    output pending_a, pending_b,
    output count
  );
endinterface

// File: rtl/register_writeback.sv
// Write-side front end for the general purpose register file. ALU and
// memory-load writebacks are queued in a small in-order FIFO and drained one
// per cycle onto the register file write port. The write port has no enable,
// so an idle cycle drives address 0 / data 0, which keeps r0 at zero.
// Per-register pending flags let decode stall on operands still in flight.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module register_writeback #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 4,
  parameter int DEPTH        = 4
) (
  input  logic                clk,
  input  logic                clr,
  register_writeback_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0]           ptr_t;
  typedef logic [CW-1:0]           cnt_t;
  typedef logic [ADDRESS_BITS-1:0] addr_t;
  typedef logic [BITS-1:0]         data_t;

  addr_t fifo_addr_q [DEPTH];
  addr_t fifo_addr_d [DEPTH];
  data_t fifo_data_q [DEPTH];
  data_t fifo_data_d [DEPTH];

  ptr_t  head_q, head_d;
  ptr_t  tail_q, tail_d;
  cnt_t  count_q, count_d;
  addr_t wb_addr_q, wb_addr_d;
  data_t wb_data_q, wb_data_d;

  cnt_t  free_slots;
  ptr_t  alu_slot;
  logic  mem_ready, alu_ready;
  logic  mem_push, alu_push, pop;
  logic  occupied [DEPTH];
  logic  pending_a, pending_b;

  // Readies depend only on occupancy and mem_valid, never on this cycle's pop;
  // memory wins the last free slot. r0 requests handshake but are dropped.
  always_comb begin
    free_slots = cnt_t'(DEPTH) - count_q;
    mem_ready  = !clr && (free_slots >= cnt_t'(1));
    alu_ready  = !clr && ((free_slots >= cnt_t'(2)) ||
                          ((free_slots == cnt_t'(1)) && !bus.mem_valid));
    mem_push   = bus.mem_valid && mem_ready && (bus.mem_addr != '0);
    alu_push   = bus.alu_valid && alu_ready && (bus.alu_addr != '0);
    pop        = (count_q != '0);
  end

  // Next FIFO contents, pointers, occupancy and write-port value; a memory
  // entry accepted together with an ALU entry goes in first (it is older).
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    head_d      = head_q;
    wb_addr_d   = '0;
    wb_data_d   = '0;
    alu_slot    = tail_q + ptr_t'(mem_push);
    if (pop) begin
      wb_addr_d = fifo_addr_q[head_q];
      wb_data_d = fifo_data_q[head_q];
      head_d    = head_q + ptr_t'(1);
    end
    if (mem_push) begin
      fifo_addr_d[tail_q] = bus.mem_addr;
      fifo_data_d[tail_q] = bus.mem_data;
    end
    if (alu_push) begin
      fifo_addr_d[alu_slot] = bus.alu_addr;
      fifo_data_d[alu_slot] = bus.alu_data;
    end
    tail_d  = tail_q + ptr_t'(mem_push) + ptr_t'(alu_push);
    count_d = count_q + cnt_t'(mem_push) + cnt_t'(alu_push) - cnt_t'(pop);
  end

  // Control state and the registered write port; clr drops everything queued.
  always_ff @(posedge clk) begin
    if (clr) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, ptr_t'(ptr_t'(i) - head_q)} < count_q);
    end
  end

  // Operand is pending if any queued entry or the undelivered write-port
  // value targets it; r0 is never pending.
  always_comb begin
    pending_a = (wb_addr_q != '0) && (wb_addr_q == bus.rd_addr_a);
    pending_b = (wb_addr_q != '0) && (wb_addr_q == bus.rd_addr_b);
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (fifo_addr_q[i] == bus.rd_addr_a)) pending_a = 1'b1;
      if (occupied[i] && (fifo_addr_q[i] == bus.rd_addr_b)) pending_b = 1'b1;
    end
    if (bus.rd_addr_a == '0) pending_a = 1'b0;
    if (bus.rd_addr_b == '0) pending_b = 1'b0;
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.pending_a = pending_a;
  assign bus.pending_b = pending_b;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback. Accepted non-r0 requests are queued
// as expected write-port values; a negedge monitor compares every non-idle
// write-port cycle against the head of that queue.
module tb_register_writeback;

  localparam int BITS  = 32;
  localparam int AB    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AB-1:0]   addr;
    logic [BITS-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic monOn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  wb_t  expQ[$];
  wb_t  monExp;

  register_writeback_if #(.BITS(BITS), .ADDRESS_BITS(AB), .DEPTH(DEPTH)) bus ();

  register_writeback #(.BITS(BITS), .ADDRESS_BITS(AB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive both request channels, check the readies the model expects, and
  // queue the writes that should eventually reach the register file.
  task automatic applyStimulus(input logic mv, input logic [AB-1:0] ma,
                               input logic [BITS-1:0] md, input logic av,
                               input logic [AB-1:0] aa, input logic [BITS-1:0] ad,
                               input logic expMemRdy, input logic expAluRdy);
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    #1;
    checkOutput("mem_ready", 64'(bus.mem_ready), 64'(expMemRdy));
    checkOutput("alu_ready", 64'(bus.alu_ready), 64'(expAluRdy));
    if (mv && expMemRdy && ma != '0) expQ.push_back('{addr: ma, data: md});
    if (av && expAluRdy && aa != '0) expQ.push_back('{addr: aa, data: ad});
  endtask

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b0;
    end
  endtask

  // Monitor: every non-idle write-port cycle must be the next expected write.
  always @(negedge clk) begin
    if (monOn && (bus.wb_addr !== '0 || bus.wb_data !== '0)) begin
      if (expQ.size() == 0) begin
        checkOutput("wb_unexpected", {28'd0, bus.wb_addr, bus.wb_data}, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wb_addr", 64'(bus.wb_addr), 64'(monExp.addr));
        checkOutput("wb_data", 64'(bus.wb_data), 64'(monExp.data));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.rd_addr_a = '0;   bus.rd_addr_b = '0;

    // Reset: readies held low while clr is asserted, state cleared.
    stepClock(2);
    applyStimulus(1, 4'd1, 32'd1, 1, 4'd2, 32'd2, 0, 0);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    checkOutput("rst_wb_data", 64'(bus.wb_data), 64'd0);
    stepClock(1);
    clr = 1'b0;
    monOn = 1'b1;
    checkOutput("rst_count_after", 64'(bus.count), 64'd0);

    // Single write with pending tracking on operand A.
    bus.rd_addr_a = 4'd11;
    applyStimulus(0, 4'd0, 32'd0, 1, 4'd11, 32'd853, 1, 1);
    checkOutput("single_pend_pre", 64'(bus.pending_a), 64'd0);
    stepClock(1);
    checkOutput("single_pend_q", 64'(bus.pending_a), 64'd1);
    checkOutput("single_count1", 64'(bus.count), 64'd1);
    checkOutput("single_wb_idle", 64'(bus.wb_addr), 64'd0);
    stepClock(1);
    checkOutput("single_wb_addr", 64'(bus.wb_addr), 64'd11);
    checkOutput("single_pend_wb", 64'(bus.pending_a), 64'd1);
    checkOutput("single_count0", 64'(bus.count), 64'd0);
    stepClock(1);
    checkOutput("single_wb_done", 64'(bus.wb_addr), 64'd0);
    checkOutput("single_pend_done", 64'(bus.pending_a), 64'd0);

    // Dual accept: mem is older than alu.
    applyStimulus(1, 4'd4, 32'd124, 1, 4'd15, 32'd888, 1, 1);
    stepClock(1);
    checkOutput("dual_count", 64'(bus.count), 64'd2);
    stepClock(3);
    checkOutput("dual_drained", 64'(bus.count), 64'd0);

    // Priority with one free slot, then ALU-only and free>=2 acceptance.
    applyStimulus(1, 4'd1, 32'd10, 1, 4'd2, 32'd20, 1, 1);
    stepClock(1);
    checkOutput("prio_count2", 64'(bus.count), 64'd2);
    applyStimulus(1, 4'd3, 32'd30, 1, 4'd5, 32'd50, 1, 1);
    stepClock(1);
    checkOutput("prio_count3", 64'(bus.count), 64'd3);
    applyStimulus(1, 4'd6, 32'd60, 1, 4'd8, 32'd80, 1, 0);
    stepClock(1);
    checkOutput("prio_count3_hold", 64'(bus.count), 64'd3);
    applyStimulus(0, 4'd0, 32'd0, 1, 4'd8, 32'd80, 1, 1);
    stepClock(1);
    checkOutput("prio_alu_only", 64'(bus.count), 64'd3);
    stepClock(1);
    checkOutput("prio_count_drop", 64'(bus.count), 64'd2);
    applyStimulus(1, 4'd9, 32'd90, 1, 4'd10, 32'd100, 1, 1);
    stepClock(1);
    checkOutput("prio_refill", 64'(bus.count), 64'd3);
    stepClock(4);
    checkOutput("prio_drained", 64'(bus.count), 64'd0);

    // r0 request handshakes but is discarded.
    bus.rd_addr_a = 4'd0;
    applyStimulus(1, 4'd0, 32'd999, 0, 4'd0, 32'd0, 1, 1);
    checkOutput("r0_pend_pre", 64'(bus.pending_a), 64'd0);
    stepClock(1);
    checkOutput("r0_count", 64'(bus.count), 64'd0);
    checkOutput("r0_wb_data", 64'(bus.wb_data), 64'd0);
    checkOutput("r0_pend", 64'(bus.pending_a), 64'd0);
    stepClock(1);
    checkOutput("r0_wb_addr", 64'(bus.wb_addr), 64'd0);

    // Same-register ordering on operand B.
    bus.rd_addr_b = 4'd7;
    applyStimulus(0, 4'd0, 32'd0, 1, 4'd7, 32'd1, 1, 1);
    checkOutput("same_pend_pre", 64'(bus.pending_b), 64'd0);
    stepClock(1);
    checkOutput("same_pend1", 64'(bus.pending_b), 64'd1);
    applyStimulus(0, 4'd0, 32'd0, 1, 4'd7, 32'd2, 1, 1);
    stepClock(1);
    applyStimulus(0, 4'd0, 32'd0, 1, 4'd7, 32'd3, 1, 1);
    stepClock(1);
    checkOutput("same_wb2", 64'(bus.wb_data), 64'd2);
    checkOutput("same_pend2", 64'(bus.pending_b), 64'd1);
    stepClock(1);
    checkOutput("same_wb3", 64'(bus.wb_data), 64'd3);
    checkOutput("same_pend3", 64'(bus.pending_b), 64'd1);
    stepClock(1);
    checkOutput("same_pend_done", 64'(bus.pending_b), 64'd0);
    checkOutput("same_wb_idle", 64'(bus.wb_addr), 64'd0);

    // Reset mid-stream drops buffered writes.
    bus.rd_addr_a = 4'd2;
    applyStimulus(1, 4'd1, 32'd11, 1, 4'd2, 32'd22, 1, 1);
    stepClock(1);
    applyStimulus(1, 4'd3, 32'd33, 1, 4'd4, 32'd44, 1, 1);
    stepClock(1);
    checkOutput("clr_count_pre", 64'(bus.count), 64'd3);
    checkOutput("clr_pend_pre", 64'(bus.pending_a), 64'd1);
    clr = 1'b1;
    applyStimulus(1, 4'd5, 32'd55, 1, 4'd6, 32'd66, 0, 0);
    stepClock(1);
    clr = 1'b0;
    expQ.delete();
    checkOutput("clr_count", 64'(bus.count), 64'd0);
    checkOutput("clr_wb_addr", 64'(bus.wb_addr), 64'd0);
    checkOutput("clr_wb_data", 64'(bus.wb_data), 64'd0);
    checkOutput("clr_pend", 64'(bus.pending_a), 64'd0);
    stepClock(4);
    checkOutput("clr_count_after", 64'(bus.count), 64'd0);

    stepClock(2);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
